// File: rtl/tick_period_meter.sv
// tick_period_meter: measures period and high time of a divided tick signal in clk cycles,
// estimates the divider limit that produced it, and flags lock, duty error and signal loss.
module tick_period_meter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [WIDTH-1:0] lim_est,
    output logic             meas_valid,
    output logic             locked,
    output logic             lost,
    output logic             duty_err
);

    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned DIFF_W  = CNT_W + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_TRACK  = 3'd2;
    localparam logic [2:0] S_LOCKED = 3'd3;
    localparam logic [2:0] S_LOST   = 3'd4;

    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   LIM_MAX   = CNT_W'((64'd1 << WIDTH) - 64'd1);
    localparam logic [MATCH_W-1:0] LOCK_C    = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

    logic [2:0]         state;
    logic [2:0]         state_nx;
    logic               hz_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   ht_next;
    logic [MATCH_W-1:0] match;
    logic [MATCH_W-1:0] match_nx;

    logic               rise_c;
    logic               fall_c;
    logic               timeout_c;
    logic [CNT_W-1:0]   lim_full_c;
    logic [WIDTH-1:0]   lim_calc_c;
    logic [DIFF_W-1:0]  two_h_c;
    logic [DIFF_W-1:0]  per_x_c;
    logic [DIFF_W-1:0]  diff_c;
    logic               duty_calc_c;

    logic [CNT_W-1:0]   period_nx;
    logic [CNT_W-1:0]   high_time_nx;
    logic [WIDTH-1:0]   lim_est_nx;
    logic               meas_valid_nx;
    logic               locked_nx;
    logic               lost_nx;
    logic               duty_err_nx;

    // Edge detection against the previous sample and timeout condition
    always_comb begin
        rise_c    = hz_in & ~hz_d;
        fall_c    = ~hz_in & hz_d;
        timeout_c = (cnt == TIMEOUT_C);
    end

    // Divider limit estimate and duty check for a measurement taken this cycle
    always_comb begin
        lim_full_c = '0;
        if (cnt >= CNT_W'(2)) begin
            lim_full_c = (cnt >> 1) - CNT_W'(1);
        end
        if (lim_full_c > LIM_MAX) begin
            lim_calc_c = {WIDTH{1'b1}};
        end else begin
            lim_calc_c = lim_full_c[WIDTH-1:0];
        end
        two_h_c = {1'b0, ht_next, 1'b0};
        per_x_c = {2'b00, cnt};
        if (two_h_c >= per_x_c) begin
            diff_c = two_h_c - per_x_c;
        end else begin
            diff_c = per_x_c - two_h_c;
        end
        duty_calc_c = (diff_c > DIFF_W'(1));
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx      = state;
        match_nx      = match;
        period_nx     = period;
        high_time_nx  = high_time;
        lim_est_nx    = lim_est;
        duty_err_nx   = duty_err;
        meas_valid_nx = 1'b0;
        locked_nx     = locked;
        lost_nx       = lost;

        if (rise_c && (state == S_ARMED || state == S_TRACK || state == S_LOCKED)) begin
            period_nx     = cnt;
            high_time_nx  = ht_next;
            lim_est_nx    = lim_calc_c;
            duty_err_nx   = duty_calc_c;
            meas_valid_nx = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (rise_c) begin
                    state_nx = S_ARMED;
                end
            end
            S_ARMED: begin
                if (rise_c) begin
                    state_nx = S_TRACK;
                    match_nx = MATCH_ONE;
                end else if (timeout_c) begin
                    state_nx  = S_LOST;
                    lost_nx   = 1'b1;
                    locked_nx = 1'b0;
                end
            end
            S_TRACK: begin
                if (rise_c) begin
                    if (cnt == period) begin
                        match_nx = match + MATCH_ONE;
                        if (match + MATCH_ONE == LOCK_C) begin
                            state_nx  = S_LOCKED;
                            locked_nx = 1'b1;
                        end
                    end else begin
                        match_nx = MATCH_ONE;
                    end
                end else if (timeout_c) begin
                    state_nx  = S_LOST;
                    lost_nx   = 1'b1;
                    locked_nx = 1'b0;
                end
            end
            S_LOCKED: begin
                if (rise_c) begin
                    if (cnt != period) begin
                        state_nx  = S_TRACK;
                        locked_nx = 1'b0;
                        match_nx  = MATCH_ONE;
                    end
                end else if (timeout_c) begin
                    state_nx  = S_LOST;
                    lost_nx   = 1'b1;
                    locked_nx = 1'b0;
                end
            end
            S_LOST: begin
                if (rise_c) begin
                    state_nx = S_ARMED;
                    lost_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Sample history, cycle counter, high-time latch, match count and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            hz_d       <= 1'b1;
            cnt        <= '0;
            ht_next    <= '0;
            match      <= '0;
            period     <= '0;
            high_time  <= '0;
            lim_est    <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            lost       <= 1'b0;
            duty_err   <= 1'b0;
        end else begin
            hz_d <= hz_in;
            if (rise_c) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (fall_c && state != S_IDLE) begin
                ht_next <= cnt;
            end
            match      <= match_nx;
            period     <= period_nx;
            high_time  <= high_time_nx;
            lim_est    <= lim_est_nx;
            meas_valid <= meas_valid_nx;
            locked     <= locked_nx;
            lost       <= lost_nx;
            duty_err   <= duty_err_nx;
        end
    end

endmodule

// File: tb/tb_tick_period_meter.sv
// Testbench for tick_period_meter: directed test-plan scenarios plus random waveforms,
// every cycle compared against an event-based reference model.
module tb_tick_period_meter;

    localparam int LOCK = 3;
    localparam int TMO  = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hz  = 1'b0;
    logic [15:0] period;
    logic [15:0] high_time;
    logic [7:0]  lim_est;
    logic        meas_valid;
    logic        locked;
    logic        lost;
    logic        duty_err;

    int total = 0;
    int bad   = 0;

    tick_period_meter #(
        .WIDTH(8), .CNT_W(16), .LOCK_COUNT(LOCK), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .hz_in(hz),
        .period(period), .high_time(high_time), .lim_est(lim_est),
        .meas_valid(meas_valid), .locked(locked), .lost(lost), .duty_err(duty_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time stamps of rises/falls, measured-period history
    int   t = 0;
    int   last_rise = 0;
    int   ht_lat = 0;
    bit   m_prev = 1'b1;
    bit   m_idle = 1'b1;
    bit   m_lost = 1'b0;
    bit   m_wait = 1'b0;
    int   hist[$];
    int   e_period = 0, e_high = 0, e_lim = 0;
    bit   e_valid = 0, e_locked = 0, e_lost = 0, e_duty = 0;

    function automatic int lim_of(input int p);
        int v;
        if (p < 2) return 0;
        v = p / 2 - 1;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic measure(input int el);
        int d;
        bit eq;
        e_period = el;
        e_high   = ht_lat;
        e_lim    = lim_of(el);
        d        = 2 * ht_lat - el;
        if (d < 0) d = -d;
        e_duty   = (d > 1);
        e_valid  = 1'b1;
        if (m_wait) hist.delete();
        hist.push_back(el);
        if (hist.size() > LOCK) void'(hist.pop_front());
        eq = (hist.size() >= LOCK);
        foreach (hist[i]) if (hist[i] != el) eq = 1'b0;
        e_locked = eq;
        m_wait   = 1'b0;
    endtask

    always @(posedge clk) begin
        bit rise, fall;
        int el;
        t++;
        if (!rst) begin
            e_period = 0; e_high = 0; e_lim = 0;
            e_valid = 0; e_locked = 0; e_lost = 0; e_duty = 0;
            m_prev = 1'b1; m_idle = 1'b1; m_lost = 1'b0; m_wait = 1'b0;
            ht_lat = 0; last_rise = t + 1; hist.delete();
        end else begin
            rise = hz & ~m_prev;
            fall = ~hz & m_prev;
            m_prev = hz;
            el = t - last_rise;
            if (el > 65535) el = 65535;
            e_valid = 1'b0;
            if (fall && !m_idle) ht_lat = el;
            if (rise) begin
                if (m_idle || m_lost) begin
                    m_idle = 1'b0; m_lost = 1'b0; e_lost = 1'b0;
                    m_wait = 1'b1; hist.delete();
                end else begin
                    measure(el);
                end
                last_rise = t;
            end else if (!m_idle && !m_lost && el == TMO) begin
                m_lost = 1'b1; e_lost = 1'b1; e_locked = 1'b0;
            end
        end
        #1;
        check("outs",
              64'({meas_valid, locked, lost, duty_err, period, high_time, lim_est}),
              64'({e_valid, e_locked, e_lost, e_duty, 16'(e_period), 16'(e_high), 8'(e_lim)}));
    end

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hz = v;
        end
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, h);
            hold(1'b0, l);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        hz  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_period", 64'(period), 64'd0);
        check("rst_flags", 64'({meas_valid, locked, lost, duty_err}), 64'd0);
        rst = 1'b1;

        // 5/5 square wave: lock after third measurement
        wave(5, 5, 6);
        check("p55_period", 64'(period), 64'd10);
        check("p55_high", 64'(high_time), 64'd5);
        check("p55_lim", 64'(lim_est), 64'd4);
        check("p55_lock", 64'({locked, duty_err}), 64'b10);

        // 4/4 lock then switch to 13/13
        wave(4, 4, 5);
        check("p44_lim", 64'(lim_est), 64'd3);
        wave(13, 13, 5);
        check("p1313_period", 64'(period), 64'd26);
        check("p1313_lim", 64'(lim_est), 64'd12);
        check("p1313_lock", 64'(locked), 64'd1);

        // loss of signal after lock, then resume
        wave(5, 5, 5);
        hold(1'b0, 1030);
        check("lost_flags", 64'({lost, locked}), 64'b10);
        check("lost_period", 64'(period), 64'd10);
        wave(5, 5, 4);
        check("resume_lost", 64'(lost), 64'd0);

        // duty error 3/7, then 5/6
        wave(3, 7, 4);
        check("d37_duty", 64'(duty_err), 64'd1);
        check("d37_high", 64'(high_time), 64'd3);
        check("d37_lim", 64'(lim_est), 64'd4);
        wave(5, 6, 3);
        check("d56_period", 64'(period), 64'd11);
        check("d56_duty", 64'({duty_err, lim_est}), 64'({1'b0, 8'd4}));

        // rise coinciding with cnt == TIMEOUT: rise wins
        wave(5, 5, 4);
        hold(1'b1, 5);
        hold(1'b0, 1019);
        hold(1'b1, 5);
        check("tmo_rise_lost", 64'(lost), 64'd0);
        check("tmo_rise_period", 64'(period), 64'd1024);
        hold(1'b0, 5);

        // reset pulse in LOCKED while hz is high
        wave(5, 5, 5);
        hold(1'b1, 3);
        rst_pulse();
        check("mid_rst", 64'({meas_valid, locked, lost, duty_err, period, high_time, lim_est}), 64'd0);
        hold(1'b1, 4);
        wave(5, 5, 3);

        // long period: saturated limit estimate
        wave(300, 300, 3);
        check("p300_period", 64'(period), 64'd600);
        check("p300_lim", 64'(lim_est), 64'd255);
        check("p300_high", 64'({duty_err, high_time}), 64'({1'b0, 16'd300}));

        // random waveforms, resets and near-timeout gaps
        for (int k = 0; k < 80; k++) begin
            int mode, h, l;
            mode = int'($urandom_range(0, 9));
            h    = int'($urandom_range(1, 12));
            if (mode == 0) begin
                hz = 1'($urandom_range(0, 1));
                rst_pulse();
            end else if (mode == 1) begin
                l = int'($urandom_range(1016, 1030)) - h;
                wave(h, l, 1);
            end else begin
                l = int'($urandom_range(1, 12));
                wave(h, l, int'($urandom_range(1, 5)));
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Measures a divided tick/square-wave signal (e.g. hzX from a clock divider) in units of the system clock.
- Reports full period, high time, and the divider limit that would produce the signal.
- Flags lock, duty error and loss of signal.
- Sits on the receive side of divided-clock outputs, for self-check and auto-calibration of divider settings.

Parameters:
- WIDTH, 8, width of lim_est; matches the divider lim port width.
- CNT_W, 16, width of the cycle counter, period and high_time.
- LOCK_COUNT, 3, number of consecutive identical periods required to assert locked (≥2).
- TIMEOUT, 1024, clk cycles without a rising edge before lost; must be < 2^CNT_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- hz_in  in  1  measured signal, synchronous to clk.
- period  out  CNT_W  clk cycles between the last two rising edges of hz_in.
- high_time  out  CNT_W  clk cycles from the last rise to the following fall.
- lim_est  out  WIDTH  period/2 − 1 (truncating division), saturating at 2^WIDTH−1.
- meas_valid  out  1  one-cycle pulse when period/high_time/lim_est/duty_err update.
- locked  out  1  LOCK_COUNT consecutive equal periods observed.
- lost  out  1  no rising edge for TIMEOUT cycles.
- duty_err  out  1  |2·high_time − period| > 1 for the latest measurement.

Behaviour:
- Reset (rst=0 at clk edge):
  - All outputs 0; state IDLE; cnt=0; match count 0.
  - hz_d (previous sample) resets to 1, so hz_in already high at reset release is not a rise.
- Edge detect:
  - rise = hz_in & ~hz_d; fall = ~hz_in & hz_d; hz_d <= hz_in every cycle.
- Counter:
  - On rise, cnt <= 1; otherwise cnt <= cnt+1, saturating at all-ones.
  - The value of cnt in the rise cycle equals the number of cycles since the previous rise.
- On fall (outside IDLE): high_time_next <= cnt (internal). The latched value is copied to high_time at the next measurement.
- All outputs are registered. Updates caused by a rise in cycle t are visible in cycle t+1.
- States and transitions:
  - IDLE: on rise -> ARMED. No outputs change.
  - ARMED: on rise -> TRACK, with a first measurement:
    - period <= cnt, high_time <= high_time_next.
    - lim_est, duty_err computed from these values.
    - meas_valid=1 for one cycle; match=1.
  - TRACK: on rise, measure as above.
    - If the new period equals the stored period: match++. When match reaches LOCK_COUNT -> LOCKED, locked=1 in the same update.
    - Otherwise match <= 1.
  - LOCKED: on rise, measure.
    - Equal period: stay.
    - Different period: -> TRACK, locked=0, match <= 1, in the same update as the new period.
  - ARMED/TRACK/LOCKED: if cnt == TIMEOUT and no rise this cycle -> LOST; lost=1, locked=0. period, high_time and lim_est hold their values.
  - LOST: on rise -> ARMED, lost=0, cnt <= 1. The next measurement needs one further rise.
- Arithmetic:
  - lim_est = (period >> 1) − 1. period < 2 gives lim_est = 0.
  - Results above 2^WIDTH−1 saturate to 2^WIDTH−1.
- Simultaneous rise and cnt == TIMEOUT: the rise wins (measurement taken, no LOST).
- Reset mid-operation: it overrides all state in the same edge.

Test Plan:
- Reset, then square wave with 5 high / 5 low cycles:
  - First meas_valid one cycle after the 2nd rise: period=10, high_time=5, lim_est=4, duty_err=0.
  - locked=1 with the 3rd measurement (4th rise).
- Lock at 4/4 (period=8, lim_est=3), then switch to 13/13:
  - First new meas_valid shows period=26, lim_est=12, locked=0.
  - locked reasserts after 3 equal periods.
- After lock, hold hz_in low:
  - lost=1, locked=0 exactly TIMEOUT=1024 cycles after the last rise; period stays 10.
  - Resume 5/5: lost=0 one cycle after the first rise; meas_valid after the second rise.
- 3 high / 7 low:
  - period=10, high_time=3, lim_est=4, duty_err=1.
  - 5/6 (period 11): duty_err=0, lim_est=4.
- In LOCKED, pulse rst low for one cycle while hz_in is high:
  - All outputs 0, no meas_valid.
  - No rise detected until hz_in goes low and high again; that rise only arms.
- 300 high / 300 low:
  - period=600, lim_est=255 (saturated), high_time=300, duty_err=0.
